// File: rtl/q_m_n_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// q_m_n_pkg : shared types and helpers for the signed Qm.n sequential ALU
// Rev 1.0
// ----------------------------------------------------------------------------
package q_m_n_pkg;

  localparam int ST_WIDTH = 3;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MUL   = 3'd2,
    ST_DIV   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_MUL   = 2'd1,
    OP_DIV   = 2'd2
  } op_e;

  // Largest magnitude representable for the given result sign
  function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
    logic [63:0] half;
    half = 64'd1 << (w - 1);
    return neg ? half : (half - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_m_n_seq_alu_datapath.sv
`default_nettype none
// ----------------------------------------------------------------------------
// q_m_n_datapath : operand registers, shift-add multiplier, restoring divider
// Rev 1.0
// ----------------------------------------------------------------------------
module q_m_n_datapath
  import q_m_n_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_i,
  input  logic                                 step_i,
  input  op_e                                  op_i,
  input  logic [INT_BITS+FRAC_BITS-1:0]        a_i,
  input  logic [INT_BITS+FRAC_BITS-1:0]        b_i,
  output logic                                 cnt_zero_o,
  output logic                                 b_zero_o,
  output logic [2*(INT_BITS+FRAC_BITS)-1:0]    mag_o
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int QW = W + FRAC_BITS;
  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0]  ra_q, ra_d;
  logic [2*W-1:0] rb_q, rb_d;
  logic [2*W-1:0] rc_q, rc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     rem_sh, rem_sub;
  logic           qbit;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(W-1)
  assign mag_a = a_i[W-1] ? (~a_i + W'(1)) : a_i;
  assign mag_b = b_i[W-1] ? (~b_i + W'(1)) : b_i;

  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    rem_sh  = {rc_q[W-1:0], ra_q[QW-1]};
    rem_sub = rem_sh - {1'b0, rb_q[W-1:0]};
    qbit    = (rem_sh >= {1'b0, rb_q[W-1:0]});
    if (load_i) begin
      rb_d = {{W{1'b0}}, mag_b};
      rc_d = '0;
      if (op_i == OP_DIV) begin
        ra_d  = {mag_a, {FRAC_BITS{1'b0}}};
        cnt_d = CW'(QW - 1);
      end else begin
        ra_d  = QW'(mag_a);
        cnt_d = CW'(W - 1);
      end
    end else if (step_i) begin
      cnt_d = cnt_q - CW'(1);
      if (op_i == OP_MUL) begin
        if (ra_q[0]) rc_d = rc_q + rb_q;
        ra_d = ra_q >> 1;
        rb_d = rb_q << 1;
      end else begin
        // Dividend bits shift out the top of ra while quotient bits enter below
        ra_d = {ra_q[QW-2:0], qbit};
        rc_d = (2*W)'(qbit ? rem_sub : rem_sh);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      cnt_q <= '0;
    end else begin
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      rc_q  <= rc_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero_o = (cnt_q == '0);
  assign b_zero_o   = (rb_q[W-1:0] == '0);
  assign mag_o      = (op_i == OP_DIV) ? (2*W)'(ra_q) : (rc_q >> FRAC_BITS);

endmodule
`default_nettype wire

// File: rtl/q_m_n_seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// q_m_n_seq_alu : signed Qm.n sequential multiply / divide / clear with saturation
// Rev 1.0
// ----------------------------------------------------------------------------
module q_m_n_seq_alu
  import q_m_n_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [INT_BITS+FRAC_BITS-1:0] A,
  input  logic [INT_BITS+FRAC_BITS-1:0] B,
  output logic [INT_BITS+FRAC_BITS-1:0] C,
  output logic                          carry,
  output logic                          dz,
  output logic                          rdy
);

  localparam int W = INT_BITS + FRAC_BITS;

  state_e         state_q, state_d;
  op_e            op_q, op_new, dp_op;
  logic           sign_q;
  logic [W-1:0]   c_q;
  logic           carry_q, dz_q;

  logic           ra_lt_0, ra_gt_0, ra_eq_0;
  logic           dp_load, dp_step, cnt_zero, b_zero;
  logic [2*W-1:0] mag, lim;
  logic [W-1:0]   fin_c;
  logic           fin_carry, fin_dz;

  assign ra_lt_0 = A[W-1];
  assign ra_eq_0 = (A == '0);
  assign ra_gt_0 = !ra_lt_0 && !ra_eq_0;
  assign op_new  = ra_gt_0 ? OP_MUL : (ra_lt_0 ? OP_DIV : OP_CLEAR);

  q_m_n_datapath #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dp_load),
    .step_i     (dp_step),
    .op_i       (dp_op),
    .a_i        (A),
    .b_i        (B),
    .cnt_zero_o (cnt_zero),
    .b_zero_o   (b_zero),
    .mag_o      (mag)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_new)
            OP_MUL:  state_d = ST_MUL;
            OP_DIV:  state_d = ST_DIV;
            default: state_d = ST_CLEAR;
          endcase
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_MUL:   if (cnt_zero) state_d = ST_FIN;
      ST_DIV:   if (b_zero || cnt_zero) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy     = (state_q == ST_IDLE);
    dp_load = (state_q == ST_IDLE) && start;
    dp_step = (state_q == ST_MUL) || ((state_q == ST_DIV) && !b_zero);
    dp_op   = (state_q == ST_IDLE) ? op_new : op_q;
  end

  // Final scaling: saturate against the sign-dependent limit, then negate
  always_comb begin
    lim       = (2*W)'(sat_limit(W, sign_q));
    fin_dz    = 1'b0;
    fin_carry = 1'b0;
    fin_c     = sign_q ? ~mag[W-1:0] + W'(1) : mag[W-1:0];
    if ((op_q == OP_DIV) && b_zero) begin
      fin_dz    = 1'b1;
      fin_carry = 1'b1;
      fin_c     = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else if (mag > lim) begin
      fin_carry = 1'b1;
      fin_c     = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_CLEAR;
      sign_q  <= 1'b0;
      c_q     <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_new;
            sign_q <= A[W-1] ^ B[W-1];
          end
        end
        ST_CLEAR: begin
          c_q     <= '0;
          carry_q <= 1'b0;
          dz_q    <= 1'b0;
        end
        ST_FIN: begin
          c_q     <= fin_c;
          carry_q <= fin_carry;
          dz_q    <= fin_dz;
        end
        default: ;
      endcase
    end
  end

  assign C     = c_q;
  assign carry = carry_q;
  assign dz    = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_q_m_n_seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_q_m_n_seq_alu : directed vector bench for the Qm.n sequential ALU
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_q_m_n_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic [15:0] C;
  logic        carry, dz, rdy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        carry;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  q_m_n_seq_alu #(
    .INT_BITS  (8),
    .FRAC_BITS (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .carry (carry),
    .dz    (dz),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launch one op at a negedge, count busy cycles, then check results.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ec, input logic ecy, input logic edz,
                        input int elat, input int poke,
                        input logic [15:0] pa, input logic [15:0] pb);
    int guard;
    int lat;
    guard = 0;
    while (!rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s idle-timeout: got rdy=%b expected 1", nm, rdy);
    end
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    lat = 0;
    while (!rdy && lat < 200) begin
      lat++;
      if (lat == poke) begin
        start = 1'b1; A = pa; B = pb;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({nm, " C"},     32'(C),     32'(ec));
    chk({nm, " carry"}, 32'(carry), 32'(ecy));
    chk({nm, " dz"},    32'(dz),    32'(edz));
    chk({nm, " lat"},   32'(lat),   32'(elat));
  endtask

  initial begin
    vecs[0]  = '{"mul 2x1.5",   16'h0200, 16'h0180, 16'h0300, 1'b0, 1'b0, 17};
    vecs[1]  = '{"mul ovf pos", 16'h4000, 16'h0400, 16'h7FFF, 1'b1, 1'b0, 17};
    vecs[2]  = '{"mul ovf neg", 16'h4000, 16'hFC00, 16'h8000, 1'b1, 1'b0, 17};
    vecs[3]  = '{"div -3/2",    16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25};
    vecs[4]  = '{"div -3/-2",   16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0, 25};
    vecs[5]  = '{"div by zero", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 2};
    vecs[6]  = '{"div ovf",     16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0, 25};
    vecs[7]  = '{"clear",       16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1};
    vecs[8]  = '{"mul 1x-1",    16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 17};
    vecs[9]  = '{"mul max",     16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0, 17};
    vecs[10] = '{"mul neg lim", 16'h4000, 16'hFE00, 16'h8000, 1'b0, 1'b0, 17};
    vecs[11] = '{"div trunc",   16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset rdy",   32'(rdy),   32'd1);
    chk("reset C",     32'(C),     32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset dz",    32'(dz),    32'd0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].carry,
             vecs[i].dz, vecs[i].lat, 0, 16'h0, 16'h0);

    // start during MUL with new operands must be ignored
    run_op("mul ignore start", 16'h0200, 16'h0180, 16'h0300, 1'b0, 1'b0, 17,
           5, 16'h4000, 16'h0400);

    // leave dz/carry set, then reset in the middle of a divide
    run_op("dz before rst", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 2, 0, 16'h0, 16'h0);
    A = 16'hFD00; B = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid-div busy", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort rdy",   32'(rdy),   32'd1);
    chk("abort C",     32'(C),     32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    chk("abort dz",    32'(dz),    32'd0);
    repeat (30) @(negedge clk);
    chk("abort no late write", 32'(C), 32'd0);

    run_op("post-reset div", 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25, 0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
